channel_arbiter_mux: RTL and testbench
======================================

CHANNEL_ARBITER_MUX -- requirements
Module: channel_arbiter_mux

Interface
REQ-001 The block SHALL have parameter M, default 2, meaning the number of input channels, legal range 2..128.
REQ-002 The block SHALL have parameter N, default 1, meaning the data bits per channel.
REQ-003 The block SHALL have parameter MODE, default MODE_SEL, meaning the channel choice policy: MODE_SEL (external select) or MODE_RR (round-robin).
REQ-004 Derived constant SW SHALL equal ceil(log2 M), minimum 1.
REQ-005 There SHALL be one clock; reset is asynchronous and active-low.
REQ-006 Port: clk, input, 1, sole clock, rising edge.
REQ-007 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port: select, input, SW, channel index; used only in MODE_SEL.
REQ-009 Port: in_valid, input, M, per-channel beat valid.
REQ-010 Port: in_data, input, M x N packed, per-channel data.
REQ-011 Port: in_ready, output, M, per-channel accept.
REQ-012 Port: out_valid, output, 1, output register holds a beat.
REQ-013 Port: out_data, output, N, registered beat data.
REQ-014 Port: out_chan, output, SW, source channel of the registered beat.
REQ-015 Port: out_ready, input, 1, downstream accept.

Function
REQ-016 The state SHALL be two-valued, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 accept SHALL be (EMPTY) or (FULL and out_ready).
REQ-018 In MODE_SEL, the grant SHALL be select when select<M and in_valid[select]=1; otherwise there is no grant.
REQ-019 In MODE_RR, the grant SHALL be the first channel with in_valid=1, searching from ptr upward and wrapping from M-1 to 0.
REQ-020 in_ready[i] SHALL be 1 only when accept=1, a grant exists, and i equals the grant; all other bits are 0, combinationally.
REQ-021 A transfer occurs on a rising edge when in_valid[g] and in_ready[g] are both 1. On a transfer: out_data<=in_data[g], out_chan<=g, out_valid<=1.
REQ-022 Latency SHALL be 1 cycle from input transfer to out_valid. Sustained throughput SHALL be 1 beat per cycle when out_ready is held at 1.
REQ-023 In FULL with out_ready=1 and no transfer, the next state SHALL be EMPTY (out_valid<=0).
REQ-024 Simultaneous drain and transfer SHALL leave the state FULL with the new beat loaded.
REQ-025 In FULL with out_ready=0, out_data and out_chan SHALL be held stable, and in_ready SHALL be all 0.
REQ-026 ptr SHALL update to (g+1) mod M on each transfer in MODE_RR, with g=M-1 wrapping to 0. ptr SHALL NOT change without a transfer.
REQ-027 In MODE_SEL, select>=M (possible when M is not a power of 2) SHALL grant nothing, and no beat SHALL be lost or created.
REQ-028 An input beat not granted SHALL NOT be consumed; the producer keeps its in_valid asserted.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously set out_valid=0, out_data=0, out_chan=0, ptr=0, and in_ready=all 0.
REQ-030 A reset asserted mid-operation SHALL discard any held beat. The first grant after release SHALL start from channel 0.

Structure
REQ-031 Package mux_pkg SHALL hold the mode enum (MODE_SEL, MODE_RR) and the bit-length function used for SW. The package is shared with existing multiplexers.
REQ-032 The round-robin search SHALL be a sub-module rr_arbiter (inputs: req[M], ptr; outputs: grant index, grant_valid). It is instantiated only when MODE=MODE_RR.
REQ-033 The data path SHALL be a single output register with no internal FIFO; the design target is 120-400 lines.

Verification (M=4, N=8)
REQ-034 MODE_SEL, select=2, in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 -> in_ready=4'b0100; the next cycle gives out_valid=1, out_data=8'hA5, out_chan=2.
REQ-035 MODE_SEL, select=1, in_valid=4'b0100 -> in_ready=0, and out_valid stays 0.
REQ-036 MODE_RR, all in_valid=1 with out_ready=1 for 6 cycles -> out_chan sequence is 0,1,2,3,0,1.
REQ-037 FULL with out_data=8'h3C and out_ready=0 for 3 cycles -> out_data stays 8'h3C and in_ready=0. Then out_ready=1 with in_valid=0 -> out_valid=0 the next cycle.
REQ-038 FULL, rst_n pulsed low mid-cycle -> out_valid=0 immediately. After release, MODE_RR with in_valid=4'b1001 grants channel 0 first.

Source files
------------

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared multiplexer types and helpers
package mux_pkg;

  typedef enum logic {MODE_SEL = 1'b0, MODE_RR = 1'b1} mode_e;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_e;

  // Bits needed to index 'value' entries; never less than one.
  function automatic int bit_len(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin request search starting at ptr, wrapping at M-1
module rr_arbiter #(
  parameter int M  = 2,
  parameter int SW = 1
) (
  input  logic [M-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] grant,
  output logic          grant_valid
);

  logic [SW:0] idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    // Walk from the farthest candidate back toward ptr so the nearest request is written last.
    for (int k = M - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (SW + 1)'(k);
      if (idx >= (SW + 1)'(M)) idx = idx - (SW + 1)'(M);
      if (req[idx[SW-1:0]]) begin
        grant       = idx[SW-1:0];
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/channel_arbiter_mux.sv
// rtl/channel_arbiter_mux.sv - M-channel to one-beat output register, select or round-robin choice
module channel_arbiter_mux
  import mux_pkg::*;
#(
  parameter int    M    = 2,
  parameter int    N    = 1,
  parameter mode_e MODE = MODE_SEL,
  localparam int   SW   = bit_len(M)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [SW-1:0]  select,
  input  logic [M-1:0]   in_valid,
  input  logic [M*N-1:0] in_data,
  output logic [M-1:0]   in_ready,
  output logic           out_valid,
  output logic [N-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  input  logic           out_ready
);

  out_state_e    state, state_n;
  logic          accept;
  logic          xfer;
  logic          grant_valid;
  logic [SW-1:0] grant;
  logic [N-1:0]  grant_data;

  assign accept    = (state == EMPTY) || out_ready;
  assign xfer      = accept && grant_valid;
  assign out_valid = (state == FULL);

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SW-1:0] ptr;
      logic          unused_select;

      assign unused_select = ^select;

      rr_arbiter #(.M(M), .SW(SW)) u_rr_arbiter (
        .req         (in_valid),
        .ptr         (ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ptr <= '0;
        else if (xfer) ptr <= (grant == SW'(M - 1)) ? '0 : grant + 1'b1;
      end
    end else begin : g_sel
      // Out-of-range select values match no channel and therefore grant nothing.
      always_comb begin
        grant       = select;
        grant_valid = 1'b0;
        for (int i = 0; i < M; i++)
          if (select == SW'(i)) grant_valid = in_valid[i];
      end
    end
  endgenerate

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < M; i++)
      if (grant == SW'(i)) grant_data = in_data[i*N +: N];
  end

  always_comb begin
    in_ready = '0;
    if (xfer && rst_n) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      EMPTY:   if (xfer) state_n = FULL;
      FULL:    if (out_ready) state_n = xfer ? FULL : EMPTY;
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_chan <= '0;
    end else if (xfer) begin
      out_data <= grant_data;
      out_chan <= grant;
    end
  end

endmodule

// File: tb/tb_channel_arbiter_mux.sv
// tb/tb_channel_arbiter_mux.sv - randomized model-checked bench for channel_arbiter_mux
module tb_channel_arbiter_mux;
  import mux_pkg::*;

  localparam int NI = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sel [NI];
  logic [3:0] iv  [NI];
  logic [7:0] id  [NI][4];
  logic       ordy[NI];

  logic       ov0, ov1, ov2;
  logic [7:0] od0, od1, od2;
  logic [1:0] oc0, oc1, oc2;
  logic [3:0] ir0, ir1;
  logic [2:0] ir2;

  int n_pass  = 0;
  int n_total = 0;

  bit         m_full[NI];
  logic [7:0] m_data[NI];
  int         m_chan[NI];
  int         m_ptr [NI];

  always #5 clk = ~clk;

  channel_arbiter_mux #(.M(4), .N(8), .MODE(MODE_SEL)) u_sel (
    .clk(clk), .rst_n(rst_n), .select(sel[0]), .in_valid(iv[0]),
    .in_data({id[0][3], id[0][2], id[0][1], id[0][0]}), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_chan(oc0), .out_ready(ordy[0]));

  channel_arbiter_mux #(.M(4), .N(8), .MODE(MODE_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .select(sel[1]), .in_valid(iv[1]),
    .in_data({id[1][3], id[1][2], id[1][1], id[1][0]}), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_chan(oc1), .out_ready(ordy[1]));

  channel_arbiter_mux #(.M(3), .N(8), .MODE(MODE_SEL)) u_sel3 (
    .clk(clk), .rst_n(rst_n), .select(sel[2]), .in_valid(iv[2][2:0]),
    .in_data({id[2][2], id[2][1], id[2][0]}), .in_ready(ir2),
    .out_valid(ov2), .out_data(od2), .out_chan(oc2), .out_ready(ordy[2]));

  function automatic int m_of(input int k);
    return (k == 2) ? 3 : 4;
  endfunction

  function automatic string name_of(input int k);
    return (k == 0) ? "sel" : (k == 1) ? "rr" : "sel3";
  endfunction

  task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", what, act, exp);
  endtask

  // Which channel the rules allow to move this cycle, from the model's own pointer.
  task automatic find_grant(input int k, output bit v, output int g);
    v = 1'b0;
    g = 0;
    if (k == 1) begin
      for (int s = 0; s < m_of(k); s++) begin
        int c;
        c = (m_ptr[k] + s) % m_of(k);
        if (!v && iv[k][c]) begin
          v = 1'b1;
          g = c;
        end
      end
    end else if (int'(sel[k]) < m_of(k)) begin
      if (iv[k][sel[k]]) begin
        v = 1'b1;
        g = int'(sel[k]);
      end
    end
  endtask

  task automatic check_inst(input int k, input logic ov, input logic [7:0] od,
                            input logic [1:0] oc, input logic [3:0] ir);
    bit         v;
    bit         acc;
    int         g;
    logic [3:0] exp_ir;
    if (!rst_n) begin
      chk({name_of(k), ".rst.in_ready"}, 32'(ir), 32'h0);
      chk({name_of(k), ".rst.out_valid"}, 32'(ov), 32'h0);
      chk({name_of(k), ".rst.out_data"}, 32'(od), 32'h0);
      chk({name_of(k), ".rst.out_chan"}, 32'(oc), 32'h0);
      m_full[k] = 1'b0;
      m_data[k] = 8'h00;
      m_chan[k] = 0;
      m_ptr[k]  = 0;
      return;
    end
    find_grant(k, v, g);
    acc    = !m_full[k] || ordy[k];
    exp_ir = (acc && v) ? 4'(1 << g) : 4'b0000;
    chk({name_of(k), ".in_ready"}, 32'(ir), 32'(exp_ir));
    chk({name_of(k), ".out_valid"}, 32'(ov), 32'(m_full[k]));
    if (m_full[k]) begin
      chk({name_of(k), ".out_data"}, 32'(od), 32'(m_data[k]));
      chk({name_of(k), ".out_chan"}, 32'(oc), 32'(m_chan[k]));
    end
    if (acc && v) begin
      m_full[k] = 1'b1;
      m_data[k] = id[k][g];
      m_chan[k] = g;
      if (k == 1) m_ptr[k] = (g + 1) % m_of(k);
    end else if (m_full[k] && ordy[k]) begin
      m_full[k] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    check_inst(0, ov0, od0, oc0, ir0);
    check_inst(1, ov1, od1, oc1, ir1);
    check_inst(2, ov2, od2, oc2, {1'b0, ir2});
  end

  task automatic idle(input int k);
    sel[k]  = 2'd0;
    iv[k]   = 4'h0;
    ordy[k] = 1'b0;
    for (int i = 0; i < 4; i++) id[k][i] = 8'h00;
  endtask

  task automatic randomize_inputs();
    for (int k = 0; k < NI; k++) begin
      sel[k] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) iv[k] = 4'($urandom) & ((k == 2) ? 4'h7 : 4'hF);
      for (int i = 0; i < 4; i++) id[k][i] = 8'($urandom);
      ordy[k] = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    logic [1:0] rr_seq [6];
    rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int k = 0; k < NI; k++) idle(k);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    sel[0] = 2'd2; iv[0] = 4'b0100; id[0][2] = 8'hA5; ordy[0] = 1'b1;
    iv[1] = 4'b1111; ordy[1] = 1'b1;
    for (int i = 0; i < 4; i++) id[1][i] = 8'(16 + i);
    @(negedge clk);
    chk("lit.sel.in_ready_grant", 32'(ir0), 32'h4);
    chk("lit.rr.in_ready_first", 32'(ir1), 32'h1);
    @(posedge clk);
    #1 sel[0] = 2'd1;

    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk($sformatf("lit.rr.out_chan[%0d]", j), 32'(oc1), 32'(rr_seq[j]));
      if (j == 0) begin
        chk("lit.sel.out_valid", 32'(ov0), 32'h1);
        chk("lit.sel.out_data", 32'(od0), 32'hA5);
        chk("lit.sel.out_chan", 32'(oc0), 32'h2);
        chk("lit.sel.no_grant_ready", 32'(ir0), 32'h0);
      end
      if (j == 1) chk("lit.sel.stays_empty", 32'(ov0), 32'h0);
    end

    @(posedge clk);
    #1 sel[0] = 2'd0; iv[0] = 4'b0001; id[0][0] = 8'h3C; ordy[0] = 1'b0;
    @(negedge clk);
    chk("lit.sel.load_ready", 32'(ir0), 32'h1);
    @(posedge clk);
    #1 id[0][0] = 8'h77;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk($sformatf("lit.sel.hold_data[%0d]", r), 32'(od0), 32'h3C);
      chk($sformatf("lit.sel.hold_ready[%0d]", r), 32'(ir0), 32'h0);
    end
    @(posedge clk);
    #1 ordy[0] = 1'b1; iv[0] = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk("lit.sel.drained", 32'(ov0), 32'h0);

    chk("lit.rr.full_before_reset", 32'(ov1), 32'h1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("lit.rr.async_clear", 32'(ov1), 32'h0);
    iv[1] = 4'b1001; ordy[1] = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("lit.rr.first_after_reset", 32'(ir1), 32'h1);
    @(negedge clk);
    chk("lit.rr.chan_after_reset", 32'(oc1), 32'h0);

    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1 randomize_inputs();
    end
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
